// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: ALU op codes, ALUOp classes, R-type funct values
// and the packed ID/EX control bundle.
package pipe_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_SGE = 4'b1000,
    ALU_SLL = 4'b1001,
    ALU_SRL = 4'b1010,
    ALU_NOR = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_SLTI  = 2'b11
  } aluop_e;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       alusrc;
    logic [1:0] aluop;
    logic [5:0] funct;
  } ctrl_t;

endpackage

// File: rtl/alu_ctrl.sv
// ALUOp/funct decoder: ALU op, shift source selects, overflow enable, illegal flag.
// Purely combinational, no flow control.
module alu_ctrl
  import pipe_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [3:0] op_o,
  output logic       shift_shamt_o,
  output logic       shift_var_o,
  output logic       ovf_en_o,
  output logic       illegal_o
);

  always_comb begin
    op_o          = ALU_AND;
    shift_shamt_o = 1'b0;
    shift_var_o   = 1'b0;
    ovf_en_o      = 1'b0;
    illegal_o     = 1'b0;
    case (aluop_i)
      ALUOP_ADD:  op_o = ALU_ADD;
      ALUOP_SUB:  op_o = ALU_SUB;
      ALUOP_SLTI: op_o = ALU_SLT;
      default: begin
        case (funct_i)
          FN_ADD:  begin op_o = ALU_ADD; ovf_en_o = 1'b1; end
          FN_ADDU: op_o = ALU_ADD;
          FN_SUB:  begin op_o = ALU_SUB; ovf_en_o = 1'b1; end
          FN_SUBU: op_o = ALU_SUB;
          FN_AND:  op_o = ALU_AND;
          FN_OR:   op_o = ALU_OR;
          FN_NOR:  op_o = ALU_NOR;
          FN_SLT:  op_o = ALU_SLT;
          FN_SLL:  begin op_o = ALU_SLL; shift_shamt_o = 1'b1; end
          FN_SRL:  begin op_o = ALU_SRL; shift_shamt_o = 1'b1; end
          FN_SLLV: begin op_o = ALU_SLL; shift_var_o = 1'b1; end
          FN_SRLV: begin op_o = ALU_SRL; shift_var_o = 1'b1; end
          default: illegal_o = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register with forwarding and ALU operand/op selection; 1-cycle latency, outputs comb.
// Backpressure: stall_i holds contents (with WB capture), flush_i inserts a bubble and wins.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          id_valid_i,
  input  logic [DW-1:0] id_rs_data_i,
  input  logic [DW-1:0] id_rt_data_i,
  input  logic [DW-1:0] id_imm_i,
  input  logic [4:0]    id_shamt_i,
  input  logic [RW-1:0] id_rs_i,
  input  logic [RW-1:0] id_rt_i,
  input  logic [RW-1:0] id_rd_i,
  input  logic [1:0]    id_aluop_i,
  input  logic [5:0]    id_funct_i,
  input  logic          id_alusrc_i,
  input  logic          id_regwrite_i,
  input  logic          id_memread_i,
  input  logic          id_memwrite_i,
  input  logic          exm_regwrite_i,
  input  logic [RW-1:0] exm_rd_i,
  input  logic [DW-1:0] exm_result_i,
  input  logic          wb_regwrite_i,
  input  logic [RW-1:0] wb_rd_i,
  input  logic [DW-1:0] wb_data_i,
  output logic [DW-1:0] aluSrc1_o,
  output logic [DW-1:0] aluSrc2_o,
  output logic [3:0]    ALU_operation_o,
  output logic [DW-1:0] store_data_o,
  output logic [RW-1:0] rd_o,
  output logic          regwrite_o,
  output logic          memread_o,
  output logic          memwrite_o,
  output logic          ovf_en_o,
  output logic          illegal_o,
  output logic          valid_o
);

  logic          valid_q, valid_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic [DW-1:0] rs_data_q, rs_data_d;
  logic [DW-1:0] rt_data_q, rt_data_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [4:0]    shamt_q, shamt_d;
  logic [RW-1:0] rs_q, rs_d;
  logic [RW-1:0] rt_q, rt_d;
  logic [RW-1:0] rd_q, rd_d;

  logic          wb_hit_rs, wb_hit_rt;

  assign wb_hit_rs = wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == rs_q);
  assign wb_hit_rt = wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == rt_q);

  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    shamt_d   = shamt_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    if (flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (stall_i) begin
      // Writes retiring during a stall would otherwise be missed once forwarding moves on.
      if (wb_hit_rs) rs_data_d = wb_data_i;
      if (wb_hit_rt) rt_data_d = wb_data_i;
    end else begin
      valid_d   = id_valid_i;
      ctrl_d    = '{regwrite: id_regwrite_i, memread: id_memread_i,
                    memwrite: id_memwrite_i, alusrc: id_alusrc_i,
                    aluop: id_aluop_i, funct: id_funct_i};
      rs_data_d = id_rs_data_i;
      rt_data_d = id_rt_data_i;
      imm_d     = id_imm_i;
      shamt_d   = id_shamt_i;
      rs_d      = id_rs_i;
      rt_d      = id_rt_i;
      rd_d      = id_rd_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      shamt_q   <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      shamt_q   <= shamt_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
    end
  end

  logic [DW-1:0] fwd_a, fwd_b;

  // EX/MEM is the younger producer, so it takes priority; r0 never forwards.
  always_comb begin
    fwd_a = rs_data_q;
    if (exm_regwrite_i && (exm_rd_i != '0) && (exm_rd_i == rs_q)) fwd_a = exm_result_i;
    else if (wb_hit_rs)                                           fwd_a = wb_data_i;
    fwd_b = rt_data_q;
    if (exm_regwrite_i && (exm_rd_i != '0) && (exm_rd_i == rt_q)) fwd_b = exm_result_i;
    else if (wb_hit_rt)                                           fwd_b = wb_data_i;
  end

  logic [3:0] op;
  logic       shift_shamt, shift_var, ovf_en, illegal;

  alu_ctrl u_alu_ctrl (
    .aluop_i       (ctrl_q.aluop),
    .funct_i       (ctrl_q.funct),
    .op_o          (op),
    .shift_shamt_o (shift_shamt),
    .shift_var_o   (shift_var),
    .ovf_en_o      (ovf_en),
    .illegal_o     (illegal)
  );

  always_comb begin
    aluSrc1_o = fwd_a;
    aluSrc2_o = ctrl_q.alusrc ? imm_q : fwd_b;
    if (shift_shamt) begin
      aluSrc1_o = fwd_b;
      aluSrc2_o = {{(DW-5){1'b0}}, shamt_q};
    end else if (shift_var) begin
      aluSrc1_o = fwd_b;
      aluSrc2_o = {{(DW-5){1'b0}}, fwd_a[4:0]};
    end
  end

  // Bubbles present a neutral AND so reset and flush look identical downstream.
  assign ALU_operation_o = valid_q ? op : 4'b0000;
  assign store_data_o    = fwd_b;
  assign rd_o            = rd_q;
  assign regwrite_o      = valid_q & ctrl_q.regwrite;
  assign memread_o       = valid_q & ctrl_q.memread;
  assign memwrite_o      = valid_q & ctrl_q.memwrite;
  assign ovf_en_o        = valid_q & ovf_en;
  assign illegal_o       = valid_q & illegal;
  assign valid_o         = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode/source-select table plus forwarding,
// stall-capture, flush and reset sequences.
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        stall_i, flush_i, id_valid_i;
  logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i;
  logic [4:0]  id_shamt_i, id_rs_i, id_rt_i, id_rd_i;
  logic [1:0]  id_aluop_i;
  logic [5:0]  id_funct_i;
  logic        id_alusrc_i, id_regwrite_i, id_memread_i, id_memwrite_i;
  logic        exm_regwrite_i, wb_regwrite_i;
  logic [4:0]  exm_rd_i, wb_rd_i;
  logic [31:0] exm_result_i, wb_data_i;
  logic [31:0] aluSrc1_o, aluSrc2_o, store_data_o;
  logic [3:0]  ALU_operation_o;
  logic [4:0]  rd_o;
  logic        regwrite_o, memread_o, memwrite_o, ovf_en_o, illegal_o, valid_o;

  int total = 0;
  int bad   = 0;

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i),
    .id_imm_i(id_imm_i), .id_shamt_i(id_shamt_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_rd_i(id_rd_i), .id_aluop_i(id_aluop_i), .id_funct_i(id_funct_i),
    .id_alusrc_i(id_alusrc_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .id_memwrite_i(id_memwrite_i), .exm_regwrite_i(exm_regwrite_i), .exm_rd_i(exm_rd_i),
    .exm_result_i(exm_result_i), .wb_regwrite_i(wb_regwrite_i), .wb_rd_i(wb_rd_i),
    .wb_data_i(wb_data_i), .aluSrc1_o(aluSrc1_o), .aluSrc2_o(aluSrc2_o),
    .ALU_operation_o(ALU_operation_o), .store_data_o(store_data_o), .rd_o(rd_o),
    .regwrite_o(regwrite_o), .memread_o(memread_o), .memwrite_o(memwrite_o),
    .ovf_en_o(ovf_en_o), .illegal_o(illegal_o), .valid_o(valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] rs_d, rt_d, imm;
    logic [4:0]  shamt;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic        alusrc, rw, mr, mw;
    logic [31:0] e_s1, e_s2;
    logic [3:0]  e_op;
    logic        e_ovf, e_ill;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [31:0] rs_d, input logic [31:0] rt_d, input logic [31:0] imm,
                     input logic [4:0] shamt, input logic [1:0] aluop, input logic [5:0] funct,
                     input logic alusrc, input logic rw, input logic mr, input logic mw,
                     input logic [31:0] e_s1, input logic [31:0] e_s2, input logic [3:0] e_op,
                     input logic e_ovf, input logic e_ill);
    vec_t v;
    v.rs_d = rs_d; v.rt_d = rt_d; v.imm = imm; v.shamt = shamt; v.aluop = aluop;
    v.funct = funct; v.alusrc = alusrc; v.rw = rw; v.mr = mr; v.mw = mw;
    v.e_s1 = e_s1; v.e_s2 = e_s2; v.e_op = e_op; v.e_ovf = e_ovf; v.e_ill = e_ill;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    stall_i = 0; flush_i = 0; id_valid_i = 0;
    id_rs_data_i = 0; id_rt_data_i = 0; id_imm_i = 0; id_shamt_i = 0;
    id_rs_i = 0; id_rt_i = 0; id_rd_i = 0; id_aluop_i = 0; id_funct_i = 0;
    id_alusrc_i = 0; id_regwrite_i = 0; id_memread_i = 0; id_memwrite_i = 0;
    exm_regwrite_i = 0; exm_rd_i = 0; exm_result_i = 0;
    wb_regwrite_i = 0; wb_rd_i = 0; wb_data_i = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n_i = 0;
    #12;
    check("rst_valid", valid_o, 0);
    check("rst_op", ALU_operation_o, 4'b0000);
    check("rst_src1", aluSrc1_o, 0);
    check("rst_src2", aluSrc2_o, 0);
    rst_n_i = 1;

    //   rs_d        rt_d        imm          sh  op     fn     src rw mr mw  e_s1        e_s2         e_op     ovf ill
    add(32'd7,      32'd3,      32'd0,       0, 2'b10, 6'h22, 0, 1, 0, 0, 32'd7,      32'd3,       4'b0110, 1, 0);
    add(32'h100,    32'h5,      32'h10,      0, 2'b00, 6'h00, 1, 1, 1, 0, 32'h100,    32'h10,      4'b0010, 0, 0);
    add(32'h200,    32'h77,     32'hFFFFFFFC,0, 2'b00, 6'h00, 1, 0, 0, 1, 32'h200,    32'hFFFFFFFC,4'b0010, 0, 0);
    add(32'h9,      32'h1,      32'd0,       4, 2'b10, 6'h00, 0, 1, 0, 0, 32'h1,      32'h4,       4'b1001, 0, 0);
    add(32'h23,     32'h80,     32'd0,       7, 2'b10, 6'h04, 0, 1, 0, 0, 32'h80,     32'h3,       4'b1001, 0, 0);
    add(32'h5,      32'hF0,     32'd0,       2, 2'b10, 6'h02, 0, 1, 0, 0, 32'hF0,     32'h2,       4'b1010, 0, 0);
    add(32'h3F,     32'hF0,     32'd0,       2, 2'b10, 6'h06, 0, 1, 0, 0, 32'hF0,     32'h1F,      4'b1010, 0, 0);
    add(32'hF0F0,   32'hFF00,   32'd0,       0, 2'b10, 6'h24, 0, 1, 0, 0, 32'hF0F0,   32'hFF00,    4'b0000, 0, 0);
    add(32'hF0F0,   32'hFF00,   32'd0,       0, 2'b10, 6'h25, 0, 1, 0, 0, 32'hF0F0,   32'hFF00,    4'b0001, 0, 0);
    add(32'h1,      32'h2,      32'd0,       0, 2'b10, 6'h27, 0, 1, 0, 0, 32'h1,      32'h2,       4'b1100, 0, 0);
    add(32'h1,      32'h2,      32'd0,       0, 2'b10, 6'h2A, 0, 1, 0, 0, 32'h1,      32'h2,       4'b0111, 0, 0);
    add(32'hA,      32'hB,      32'd0,       0, 2'b10, 6'h21, 0, 1, 0, 0, 32'hA,      32'hB,       4'b0010, 0, 0);
    add(32'hA,      32'hB,      32'd0,       0, 2'b10, 6'h20, 0, 1, 0, 0, 32'hA,      32'hB,       4'b0010, 1, 0);
    add(32'hA,      32'hB,      32'd0,       0, 2'b10, 6'h23, 0, 1, 0, 0, 32'hA,      32'hB,       4'b0110, 0, 0);
    add(32'hC,      32'hD,      32'h99,      0, 2'b01, 6'h20, 0, 0, 0, 0, 32'hC,      32'hD,       4'b0110, 0, 0);
    add(32'hC,      32'hD,      32'h30,      0, 2'b11, 6'h22, 1, 1, 0, 0, 32'hC,      32'h30,      4'b0111, 0, 0);
    add(32'h11,     32'h22,     32'd0,       3, 2'b10, 6'h3F, 0, 1, 0, 0, 32'h11,     32'h22,      4'b0000, 0, 1);

    foreach (vq[i]) begin
      id_valid_i = 1; id_rs_i = 5'd1; id_rt_i = 5'd2; id_rd_i = 5'(i + 10);
      id_rs_data_i = vq[i].rs_d; id_rt_data_i = vq[i].rt_d; id_imm_i = vq[i].imm;
      id_shamt_i = vq[i].shamt; id_aluop_i = vq[i].aluop; id_funct_i = vq[i].funct;
      id_alusrc_i = vq[i].alusrc; id_regwrite_i = vq[i].rw;
      id_memread_i = vq[i].mr; id_memwrite_i = vq[i].mw;
      step();
      check($sformatf("v%0d_src1", i), aluSrc1_o, vq[i].e_s1);
      check($sformatf("v%0d_src2", i), aluSrc2_o, vq[i].e_s2);
      check($sformatf("v%0d_op", i), ALU_operation_o, vq[i].e_op);
      check($sformatf("v%0d_ovf", i), ovf_en_o, vq[i].e_ovf);
      check($sformatf("v%0d_ill", i), illegal_o, vq[i].e_ill);
      check($sformatf("v%0d_store", i), store_data_o, vq[i].rt_d);
      check($sformatf("v%0d_rd", i), rd_o, i + 10);
      check($sformatf("v%0d_rw", i), regwrite_o, vq[i].rw);
      check($sformatf("v%0d_mr", i), memread_o, vq[i].mr);
      check($sformatf("v%0d_mw", i), memwrite_o, vq[i].mw);
      check($sformatf("v%0d_valid", i), valid_o, 1);
    end

    // Asynchronous reset mid-stream with a valid instruction held at the input.
    #2 rst_n_i = 0;
    #1;
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_rw", regwrite_o, 0);
    check("mid_rst_op", ALU_operation_o, 4'b0000);
    check("mid_rst_ill", illegal_o, 0);
    check("mid_rst_src1", aluSrc1_o, 0);
    check("mid_rst_src2", aluSrc2_o, 0);
    check("mid_rst_store", store_data_o, 0);
    #1 rst_n_i = 1;

    // Forwarding priority on rs and rt.
    idle_inputs();
    id_valid_i = 1; id_rs_i = 5; id_rt_i = 6; id_rs_data_i = 32'h11; id_rt_data_i = 32'h22;
    id_aluop_i = 2'b10; id_funct_i = 6'h20;
    step();
    exm_regwrite_i = 1; exm_rd_i = 5; exm_result_i = 32'hAA;
    wb_regwrite_i = 1; wb_rd_i = 5; wb_data_i = 32'hBB;
    #1 check("fwd_exm_prio", aluSrc1_o, 32'hAA);
    exm_regwrite_i = 0;
    #1 check("fwd_wb", aluSrc1_o, 32'hBB);
    wb_regwrite_i = 0;
    #1 check("fwd_none", aluSrc1_o, 32'h11);
    exm_regwrite_i = 1; exm_rd_i = 6;
    #1 check("fwd_rt_src2", aluSrc2_o, 32'hAA);
    check("fwd_rt_store", store_data_o, 32'hAA);
    exm_regwrite_i = 0;
    id_rs_i = 0; id_rs_data_i = 32'h11;
    step();
    exm_regwrite_i = 1; exm_rd_i = 0; wb_regwrite_i = 1; wb_rd_i = 0;
    #1 check("fwd_r0", aluSrc1_o, 32'h11);
    exm_regwrite_i = 0; wb_regwrite_i = 0;

    // Stall two cycles while WB retires reg 8 into the held rt.
    id_rs_i = 9; id_rt_i = 8; id_rs_data_i = 32'h44; id_rt_data_i = 32'h99;
    step();
    stall_i = 1; wb_regwrite_i = 1; wb_rd_i = 8; wb_data_i = 32'h55;
    id_rs_data_i = 32'hBEEF; id_rt_data_i = 32'hDEAD; id_valid_i = 0;
    step();
    step();
    stall_i = 0; wb_regwrite_i = 0; wb_data_i = 0;
    #1;
    check("stall_cap_src2", aluSrc2_o, 32'h55);
    check("stall_cap_store", store_data_o, 32'h55);
    check("stall_hold_src1", aluSrc1_o, 32'h44);
    check("stall_hold_valid", valid_o, 1);

    // Flush beats stall.
    id_valid_i = 1; id_regwrite_i = 1;
    step();
    check("pre_flush_rw", regwrite_o, 1);
    stall_i = 1; flush_i = 1;
    step();
    check("flush_valid", valid_o, 0);
    check("flush_rw", regwrite_o, 0);
    check("flush_op", ALU_operation_o, 4'b0000);
    stall_i = 0; flush_i = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the EX-stage ALU.
- Registers decoded operands and control, decodes ALUOp/funct into the 4-bit ALU operation, and selects immediate or shamt sources.
- Applies EX/MEM and MEM/WB forwarding and drives the ALU's aluSrc1, aluSrc2 and ALU_operation_i inputs directly.
- Supports stall (hold) and flush (bubble) from the hazard unit.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-index width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- stall_i  in  1  hold stage contents.
- flush_i  in  1  load a bubble.
- id_valid_i  in  1  ID slot holds a real instruction.
- id_rs_data_i  in  DW  rs read value.
- id_rt_data_i  in  DW  rt read value.
- id_imm_i  in  DW  extended immediate.
- id_shamt_i  in  5  shift amount.
- id_rs_i, id_rt_i, id_rd_i  in  RW  register indices (rd is already the dest mux result).
- id_aluop_i  in  2  00 add, 01 sub, 10 R-type funct, 11 slt-immediate.
- id_funct_i  in  6  funct field.
- id_alusrc_i  in  1  1 selects immediate for src2.
- id_regwrite_i, id_memread_i, id_memwrite_i  in  1  control.
- exm_regwrite_i  in  1  EX/MEM forwarding source: write enable.
- exm_rd_i  in  RW  EX/MEM forwarding source: destination.
- exm_result_i  in  DW  EX/MEM forwarding source: result.
- wb_regwrite_i  in  1  MEM/WB forwarding source: write enable.
- wb_rd_i  in  RW  MEM/WB forwarding source: destination.
- wb_data_i  in  DW  MEM/WB forwarding source: data.
- aluSrc1_o  out  DW  to ALU aluSrc1.
- aluSrc2_o  out  DW  to ALU aluSrc2.
- ALU_operation_o  out  4  to ALU ALU_operation_i.
- store_data_o  out  DW  forwarded rt value.
- rd_o  out  RW  destination.
- regwrite_o, memread_o, memwrite_o  out  1  control, gated by valid.
- ovf_en_o  out  1  overflow trap enable (signed add/sub only).
- illegal_o  out  1  unknown funct with aluop=10.
- valid_o  out  1  stage valid.

Behaviour:
- Clock and reset:
  - One clock, clk_i.
  - Reset is asynchronous and active-low: rst_n_i=0 clears every register immediately.
  - Reset or mid-operation reset: all held state 0, valid_o=0, ALU_operation_o=4'b0000, control outputs 0.
  - With exm/wb regwrite low during reset, aluSrc1_o, aluSrc2_o and store_data_o read 0.
- Register update, per rising edge:
  - flush_i=1: valid and all control clear (bubble); flush wins over stall.
  - Else stall_i=1: contents held, except stall-capture below.
  - Else: load all id_* fields; valid <= id_valid_i.
- Latency: one cycle from ID inputs to registered state. All *_o values are combinational from registered state plus forwarding inputs.
- Control gating: regwrite_o, memread_o, memwrite_o, ovf_en_o and illegal_o are forced to 0 when valid=0.
- Stall-capture: while stalled, if wb_regwrite_i=1, wb_rd_i!=0 and wb_rd_i matches held rs (rt), the held rs (rt) data is overwritten with wb_data_i. This prevents stale operands after the stall releases.
- Forwarding, per operand A=rs, B=rt:
  - EX/MEM hit if exm_regwrite_i=1, exm_rd_i!=0 and exm_rd_i==index.
  - Else MEM/WB hit under the same rule with the wb_* inputs.
  - Else the registered data.
  - EX/MEM has priority when both hit. Register 0 is never forwarded.
- Decode to ALU_operation_o:
  - aluop 00 -> 0010 ADD.
  - aluop 01 -> 0110 SUB.
  - aluop 11 -> 0111 SLT.
  - aluop 10 by funct:
    - 0x20/0x21 -> 0010.
    - 0x22/0x23 -> 0110.
    - 0x24 -> 0000.
    - 0x25 -> 0001.
    - 0x27 -> 1100.
    - 0x2A -> 0111.
    - 0x00/0x04 -> 1001 SLL.
    - 0x02/0x06 -> 1010 SRL.
    - Other funct -> 0000 with illegal_o=1.
- Source selection:
  - Shifts 0x00/0x02: aluSrc1_o = fwd rt; aluSrc2_o = zero-extended shamt.
  - Shifts 0x04/0x06: aluSrc1_o = fwd rt; aluSrc2_o = {27'b0, fwd rs[4:0]}.
  - Otherwise: aluSrc1_o = fwd rs; aluSrc2_o = id_alusrc ? imm : fwd rt.
- ovf_en_o: 1 only for funct 0x20/0x22 with aluop 10.
- store_data_o: always fwd rt.

Decomposition:
- Shared package pipe_pkg holds:
  - ALU op codes: AND, OR, ADD, SUB, SLT, SGE, SLL, SRL, NOR.
  - ALUOp codes.
  - Funct constants.
- One natural sub-module, alu_ctrl (combinational aluop/funct -> op, shift-select, ovf_en, illegal), reused by the single-cycle core.

Test Plan:
- Reset mid-stream with valid=1 held -> all outputs 0 immediately, before the next edge.
- Load funct 0x22, rs=7, rt=3, no hazards -> next cycle ALU_operation_o=0110, aluSrc1_o=7, aluSrc2_o=3, ovf_en_o=1.
- Forward priority: rs=5 with exm_rd=5 (0xAA) and wb_rd=5 (0xBB) -> aluSrc1_o=0xAA. Drop exm_regwrite -> 0xBB. Same scenario with rd=0 -> registered value.
- funct 0x00, shamt=4, rt=0x1 -> aluSrc1_o=1, aluSrc2_o=4, op=1001. funct 0x04 with rs=0x23 -> aluSrc2_o=3.
- Stall 2 cycles while wb writes reg 8=0x55 to held rt=8 -> after release, aluSrc2_o=0x55 with wb idle.
- stall_i=1 and flush_i=1 together -> valid_o=0, regwrite_o=0. funct 0x3F with aluop 10 -> illegal_o=1, op 0000.
